// File: rtl/btn_pkg.sv
// btn_pkg
// Definitions shared by every button_event_decoder instance and by the
// calendar/clock setting FSM that consumes their events.
//   btn_state_t                - decoder state encoding (ARM, IDLE, PRESSED, LONG)
//   BTN_DEFAULT_LONG_CYCLES    - long-press hold time, 1 s at 100 MHz
//   BTN_DEFAULT_REPEAT_CYCLES  - auto-repeat period, 250 ms at 100 MHz
//   BTN_DEFAULT_CTR_W          - counter width that covers both defaults
package btn_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } btn_state_t;

    localparam int BTN_DEFAULT_LONG_CYCLES   = 100_000_000;
    localparam int BTN_DEFAULT_REPEAT_CYCLES = 25_000_000;
    localparam int BTN_DEFAULT_CTR_W         = 27;

endpackage : btn_pkg

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns one debounced button level into single-cycle UI events.
// One instance is used per physical button.
//
// Build option: define AUTO_REPEAT_EN to enable the repeat_o pulses while the
// button is held past the long-press threshold. When it is undefined,
// repeat_o is tied low and REPEAT_CYCLES has no effect.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   btn_level_i  debounced level (1 = pressed), synchronous to clk_i
//   press_o      one-cycle pulse on press
//   release_o    one-cycle pulse on any release
//   short_o      one-cycle pulse on a release before the long-press threshold
//   long_o       one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//   repeat_o     one-cycle pulse every REPEAT_CYCLES after long-press
//   held_o       level, high while the button is in PRESSED or LONG
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = BTN_DEFAULT_LONG_CYCLES,
    parameter int REPEAT_CYCLES     = BTN_DEFAULT_REPEAT_CYCLES,
    parameter int CTR_W             = BTN_DEFAULT_CTR_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_level_i,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    // Reject parameter sets where the counter cannot reach a terminal count.
    if (LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 1 ||
        (64'(1) << CTR_W) <= 64'(LONG_PRESS_CYCLES) ||
        (64'(1) << CTR_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_params
        $error("button_event_decoder: illegal timing parameters");
    end

    // Counter terminal values: the transition fires at the edge where the
    // counter already holds N-1, so the event lands exactly N cycles later.
    localparam logic [CTR_W-1:0] LONG_TC = CTR_W'(LONG_PRESS_CYCLES - 1);

    btn_state_t       state_reg;
    logic [CTR_W-1:0] ctr_reg;

`ifdef AUTO_REPEAT_EN
    localparam logic [CTR_W-1:0] REPEAT_TC = CTR_W'(REPEAT_CYCLES - 1);
    logic repeat_reg;
    assign repeat_o = repeat_reg;
`else
    assign repeat_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // A pending event is simply dropped; ARM forces a release before
            // the next press can be reported.
            state_reg <= ARM;
            ctr_reg   <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            held_o    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_reg <= 1'b0;
`endif
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_reg <= 1'b0;
`endif
            case (state_reg)
                ARM: begin
                    held_o <= 1'b0;
                    if (!btn_level_i) begin
                        state_reg <= IDLE;
                        ctr_reg   <= '0;
                    end
                end

                IDLE: begin
                    if (btn_level_i) begin
                        state_reg <= PRESSED;
                        ctr_reg   <= '0;
                        press_o   <= 1'b1;
                        held_o    <= 1'b1;
                    end
                end

                PRESSED: begin
                    // Release is checked first so it wins over the terminal count.
                    if (!btn_level_i) begin
                        state_reg <= IDLE;
                        ctr_reg   <= '0;
                        release_o <= 1'b1;
                        short_o   <= 1'b1;
                        held_o    <= 1'b0;
                    end else if (ctr_reg == LONG_TC) begin
                        state_reg <= LONG;
                        ctr_reg   <= '0;
                        long_o    <= 1'b1;
                    end else begin
                        ctr_reg <= ctr_reg + CTR_W'(1);
                    end
                end

                LONG: begin
                    if (!btn_level_i) begin
                        state_reg <= IDLE;
                        ctr_reg   <= '0;
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (ctr_reg == REPEAT_TC) begin
                            ctr_reg    <= '0;
                            repeat_reg <= 1'b1;
                        end else begin
                            ctr_reg <= ctr_reg + CTR_W'(1);
                        end
`else
                        ctr_reg <= '0;
`endif
                    end
                end

                default: begin
                    state_reg <= ARM;
                    ctr_reg   <= '0;
                    held_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// Directed test of button_event_decoder with LONG_PRESS_CYCLES=8,
// REPEAT_CYCLES=3. Expected outputs follow the build's AUTO_REPEAT_EN setting.
module tb_button_event_decoder;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    // Expected output word: {press, release, short, long, repeat, held}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] P  = 6'b100001;
    localparam logic [5:0] H  = 6'b000001;
    localparam logic [5:0] RS = 6'b011000;
    localparam logic [5:0] R  = 6'b010000;
    localparam logic [5:0] L  = 6'b000101;
    localparam logic [5:0] RP = AR ? 6'b000011 : 6'b000001;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic btn_level_i = 1'b0;
    logic press_o, release_o, short_o, long_o, repeat_o, held_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst;
        bit         lvl;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_CYCLES(8),
        .REPEAT_CYCLES    (3),
        .CTR_W            (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .btn_level_i(btn_level_i),
        .press_o    (press_o),
        .release_o  (release_o),
        .short_o    (short_o),
        .long_o     (long_o),
        .repeat_o   (repeat_o),
        .held_o     (held_o)
    );

    function automatic void add(input bit r, input bit l, input logic [5:0] e);
        vec_t v;
        v.rst = r;
        v.lvl = l;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [5:0] outs();
        return {press_o, release_o, short_o, long_o, repeat_o, held_o};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end else begin
            $display("ok   %s outs=%b", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit seen;

        // ---- reset, short press of 4 cycles
        add(1, 0, Z);
        add(0, 0, Z);                         // ARM -> IDLE
        add(0, 1, P);
        for (int i = 0; i < 3; i++) add(0, 1, H);
        add(0, 0, RS);
        add(0, 0, Z);
        // ---- 20-cycle hold: long at +8, repeats at +3/+6/+9
        add(0, 1, P);
        for (int i = 0; i < 7; i++) add(0, 1, H);
        add(0, 1, L);
        for (int i = 0; i < 11; i++) add(0, 1, (i % 3 == 2) ? RP : H);
        add(0, 0, R);
        add(0, 0, Z);
        // ---- release on the edge where long would have fired
        add(0, 1, P);
        for (int i = 0; i < 7; i++) add(0, 1, H);
        add(0, 0, RS);
        // ---- press one cycle after release
        add(0, 1, P);
        add(0, 0, RS);
        add(0, 1, P);
        add(0, 0, RS);
        // ---- button held through reset: no press until released
        add(1, 1, Z);
        add(0, 1, Z);
        add(0, 1, Z);
        add(0, 0, Z);
        add(0, 1, P);
        add(0, 0, RS);
        // ---- reset in the middle of LONG
        add(0, 1, P);
        for (int i = 0; i < 7; i++) add(0, 1, H);
        add(0, 1, L);
        add(0, 1, H);
        add(1, 1, Z);
        add(0, 1, Z);                         // still ARM, no release
        add(0, 0, Z);                         // back to IDLE

        foreach (vecs[i]) begin
            rst_i       = vecs[i].rst;
            btn_level_i = vecs[i].lvl;
            step();
            check($sformatf("vec[%0d] rst=%0b lvl=%0b", i, vecs[i].rst, vecs[i].lvl),
                  outs(), vecs[i].exp);
        end

        // ---- hand-written: measure long and repeat latency with bounded waits
        btn_level_i = 1'b1;
        step();
        check("seq press", outs(), P);

        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            step();
            n++;
            seen = long_o;
        end
        checks++;
        if (!seen || n != 8) begin
            errors++;
            $display("FAIL seq long_latency got=%0d (seen=%0b) expected=8", n, seen);
        end else begin
            $display("ok   seq long_latency=%0d", n);
        end

        n = 0;
        seen = 1'b0;
        while (n < 10 && !seen) begin
            step();
            n++;
            seen = repeat_o;
        end
        checks++;
        if (AR ? (!seen || n != 3) : seen) begin
            errors++;
            $display("FAIL seq repeat_latency got=%0d (seen=%0b) expected=%0s",
                     n, seen, AR ? "3" : "none");
        end else begin
            $display("ok   seq repeat_latency n=%0d seen=%0b", n, seen);
        end

        btn_level_i = 1'b0;
        step();
        check("seq long_release", outs(), R);
        step();
        check("seq idle", outs(), Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_event_decoder
